// File: rtl/ed_stats_pkg.sv
// Shared types and default widths for the approximate-adder error-statistics collector.
package ed_stats_pkg;

  localparam int unsigned ED_N     = 16;
  localparam int unsigned ED_CNT_W = 24;
  localparam int unsigned ED_ACC_W = ED_N + ED_CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ed_abs_diff.sv
// Stage 1: registers the error distance |approx - exact| plus mismatch/zero flags for one sample.
module ed_abs_diff
  import ed_stats_pkg::*;
#(
  parameter int unsigned N = ED_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_approx,
  input  logic [N-1:0] i_exact,
  output logic         o_valid,
  output logic [N-1:0] o_ed,
  output logic         o_mismatch,
  output logic         o_zero
);

  logic         r_valid;
  logic [N-1:0] r_ed;
  logic         r_mismatch;
  logic         r_zero;
  logic [N-1:0] w_ed;

  // Subtract in the order that cannot wrap, so ed is the true N-bit distance.
  assign w_ed = (i_approx > i_exact) ? (i_approx - i_exact) : (i_exact - i_approx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ed       <= '0;
      r_mismatch <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_ed       <= w_ed;
        r_mismatch <= (i_approx != i_exact);
        r_zero     <= (i_exact == '0);
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_ed       = r_ed;
  assign o_mismatch = r_mismatch;
  assign o_zero     = r_zero;

endmodule

// File: rtl/ed_stats_collector.sv
// Error-statistics collector: run-control FSM, accept counter and stage-2 accumulators.
module ed_stats_collector
  import ed_stats_pkg::*;
#(
  parameter int unsigned N     = ED_N,
  parameter int unsigned CNT_W = ED_CNT_W,
  parameter int unsigned ACC_W = N + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     approx_sum,
  input  logic [N-1:0]     exact_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] zero_exact_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N-1:0]     max_ed
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_start;

  logic             w_s1_valid;
  logic [N-1:0]     w_s1_ed;
  logic             w_s1_mismatch;
  logic             w_s1_zero;

  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_zero_cnt;
  logic [ACC_W-1:0] r_sum_ed;
  logic [N-1:0]     r_max_ed;

  assign w_accept = in_valid && in_ready;
  assign w_last   = w_accept && (r_acc_cnt == (r_target - CNT_W'(1)));
  // start is only honoured when no run is in flight.
  assign w_start  = start && ((r_state == IDLE) || (r_state == DONE));

  ed_abs_diff #(
    .N(N)
  ) u_abs_diff (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (w_accept),
    .i_approx   (approx_sum),
    .i_exact    (exact_sum),
    .o_valid    (w_s1_valid),
    .o_ed       (w_s1_ed),
    .o_mismatch (w_s1_mismatch),
    .o_zero     (w_s1_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Stage 2 is the accumulator bank itself, so the pipeline is empty once stage 1 is.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_s1_valid) begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      RUN: begin
        busy     = 1'b1;
        in_ready = (r_acc_cnt < r_target);
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target  <= '0;
      r_acc_cnt <= '0;
    end else if (w_start) begin
      r_target  <= num_samples;
      r_acc_cnt <= '0;
    end else if (w_accept) begin
      r_acc_cnt <= r_acc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_zero_cnt   <= '0;
      r_sum_ed     <= '0;
      r_max_ed     <= '0;
    end else if (w_start) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_zero_cnt   <= '0;
      r_sum_ed     <= '0;
      r_max_ed     <= '0;
    end else if (w_s1_valid) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      r_err_cnt    <= r_err_cnt + CNT_W'(w_s1_mismatch);
      r_zero_cnt   <= r_zero_cnt + CNT_W'(w_s1_zero);
      r_sum_ed     <= r_sum_ed + ACC_W'(w_s1_ed);
      if (w_s1_ed > r_max_ed) begin
        r_max_ed <= w_s1_ed;
      end
    end
  end

  assign sample_count     = r_sample_cnt;
  assign error_count      = r_err_cnt;
  assign zero_exact_count = r_zero_cnt;
  assign sum_ed           = r_sum_ed;
  assign max_ed           = r_max_ed;

endmodule

// File: tb/tb_ed_stats_collector.sv
// Directed and randomized bench for ed_stats_collector against a queue-based statistics model.
module tb_ed_stats_collector;

  localparam int unsigned N     = 16;
  localparam int unsigned CNT_W = 24;
  localparam int unsigned ACC_W = N + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     approx_sum;
  logic [N-1:0]     exact_sum;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] error_count;
  logic [CNT_W-1:0] zero_exact_count;
  logic [ACC_W-1:0] sum_ed;
  logic [N-1:0]     max_ed;

  int n_err = 0;
  int n_chk = 0;

  logic [N-1:0] tab_a[$];
  logic [N-1:0] tab_e[$];

  ed_stats_collector #(
    .N     (N),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .num_samples      (num_samples),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .approx_sum       (approx_sum),
    .exact_sum        (exact_sum),
    .busy             (busy),
    .done             (done),
    .sample_count     (sample_count),
    .error_count      (error_count),
    .zero_exact_count (zero_exact_count),
    .sum_ed           (sum_ed),
    .max_ed           (max_ed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_pair(input logic [N-1:0] a, input logic [N-1:0] e);
    tab_a.push_back(a);
    tab_e.push_back(e);
  endtask

  task automatic clear_tab();
    tab_a.delete();
    tab_e.delete();
  endtask

  task automatic add_random_pair();
    logic [N-1:0] a;
    logic [N-1:0] e;
    a = N'($urandom);
    e = N'($urandom);
    case ($urandom % 4)
      0: e = a;
      1: begin e = '0; a = N'($urandom % 8); end
      2: ;
      default: begin
        if ($urandom % 2 == 0) begin a = '1; e = '0; end
        else begin a = '0; e = '1; end
      end
    endcase
    add_pair(a, e);
  endtask

  task automatic check_stats(input string tag, input int n);
    longint exp_sum;
    int exp_max, exp_err, exp_zero, d;
    exp_sum = 0; exp_max = 0; exp_err = 0; exp_zero = 0;
    for (int i = 0; i < n; i++) begin
      d = int'(tab_a[i]) - int'(tab_e[i]);
      if (d < 0) d = -d;
      exp_sum += longint'(d);
      if (d > exp_max) exp_max = d;
      if (tab_a[i] != tab_e[i]) exp_err++;
      if (tab_e[i] == 0) exp_zero++;
    end
    check({tag, "_sample_count"}, 64'(sample_count), 64'(n));
    check({tag, "_error_count"}, 64'(error_count), 64'(exp_err));
    check({tag, "_zero_count"}, 64'(zero_exact_count), 64'(exp_zero));
    check({tag, "_sum_ed"}, 64'(sum_ed), 64'(exp_sum));
    check({tag, "_max_ed"}, 64'(max_ed), 64'(exp_max));
  endtask

  // mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid
  task automatic run(input string tag, input int n, input int mode, input bit poke_start);
    int acc, cyc;
    bit v;
    @(negedge clk);
    num_samples = CNT_W'(n);
    start       = 1'b1;
    in_valid    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clr_samples"}, 64'(sample_count), 64'(0));
    check({tag, "_clr_sum"}, 64'(sum_ed), 64'(0));
    if (n == 0) begin
      check({tag, "_done"}, 64'(done), 64'(1));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_ready"}, 64'(in_ready), 64'(0));
      check_stats(tag, 0);
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_ready_later"}, 64'(in_ready), 64'(0));
      check({tag, "_done_held"}, 64'(done), 64'(1));
      in_valid = 1'b0;
      return;
    end
    check({tag, "_done_low"}, 64'(done), 64'(0));
    check({tag, "_busy_run"}, 64'(busy), 64'(1));
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 1000) begin
      check({tag, "_ready_run"}, 64'(in_ready), 64'(1));
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom % 2 == 0);
      endcase
      in_valid   = v;
      approx_sum = v ? tab_a[acc] : N'($urandom);
      exact_sum  = v ? tab_e[acc] : N'($urandom);
      if (poke_start && cyc == 2) begin
        start       = 1'b1;
        num_samples = CNT_W'(7);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (v) acc++;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_accept_budget"}, 64'(acc), 64'(n));
    in_valid   = 1'b1;
    approx_sum = N'($urandom);
    exact_sum  = N'($urandom);
    check({tag, "_ready_drain"}, 64'(in_ready), 64'(0));
    check({tag, "_busy_drain"}, 64'(busy), 64'(1));
    check({tag, "_done_t1"}, 64'(done), 64'(0));
    check({tag, "_lat_t1"}, 64'(sample_count), 64'(n - 1));
    @(negedge clk);
    check({tag, "_done_t2"}, 64'(done), 64'(0));
    check({tag, "_lat_t2"}, 64'(sample_count), 64'(n));
    @(negedge clk);
    check({tag, "_done_t3"}, 64'(done), 64'(1));
    check({tag, "_busy_done"}, 64'(busy), 64'(0));
    check({tag, "_ready_done"}, 64'(in_ready), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    check_stats(tag, n);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    approx_sum  = '0;
    exact_sum   = '0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_ready", 64'(in_ready), 64'(0));
    check("rst_sum", 64'(sum_ed), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    clear_tab();
    add_pair(16'h0100, 16'h0105);
    run("single", 1, 0, 1'b0);

    clear_tab();
    add_pair(16'd10, 16'd10);
    add_pair(16'd0, 16'd0);
    add_pair(16'hFFFF, 16'h0000);
    add_pair(16'd7, 16'd3);
    run("b2b", 4, 0, 1'b0);

    run("zero_len", 0, 0, 1'b0);

    clear_tab();
    add_pair(16'd100, 16'd0);
    add_pair(16'd3, 16'd9);
    add_pair(16'd42, 16'd42);
    run("gapped", 3, 1, 1'b1);

    clear_tab();
    for (int i = 0; i < 5; i++) add_pair(16'(20 + i), 16'(3 + i));
    @(negedge clk);
    num_samples = CNT_W'(5);
    start       = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    in_valid   = 1'b1;
    approx_sum = tab_a[0];
    exact_sum  = tab_e[0];
    @(negedge clk);
    approx_sum = tab_a[1];
    exact_sum  = tab_e[1];
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_pre", 64'(sample_count), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_ready", 64'(in_ready), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    check("rst_mid_samples", 64'(sample_count), 64'(0));
    check("rst_mid_err", 64'(error_count), 64'(0));
    check("rst_mid_sum", 64'(sum_ed), 64'(0));
    check("rst_mid_max", 64'(max_ed), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle_busy", 64'(busy), 64'(0));
    check("rst_idle_ready", 64'(in_ready), 64'(0));

    clear_tab();
    add_pair(16'd5, 16'd5);
    run("post_rst", 1, 0, 1'b0);

    clear_tab();
    add_pair(16'd1, 16'd2);
    add_pair(16'd4, 16'd2);
    run("restart", 2, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 24));
      clear_tab();
      for (int i = 0; i < n; i++) add_random_pair();
      run($sformatf("rand%0d", r), n, 2, ($urandom % 2 == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
